// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART transmit path.
package uart_pkg;

    localparam int UART_DATA_W   = 8;
    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_GAP    = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write port, combinational read port.
module sync_fifo_mem
    import uart_pkg::*;
#(
    parameter  int DEPTH  = DEFAULT_DEPTH,
    parameter  int DATA_W = UART_DATA_W,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage carries no reset; stale entries are never read because count gates every pop.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch controller feeding a UART transmitter one byte per done pulse.
// Optional sticky overflow flag output ovf when UART_TX_FIFO_OVF_EN is defined.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wrEn,
    input  logic [UART_DATA_W-1:0] wrData,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        count,
    output logic                   txDataValid,
    output logic [UART_DATA_W-1:0] txByte,
    input  logic                   txDone,
    output logic                   busy
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic                   ovf
`else
`endif
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]      wr_ptr;
    logic [ADDR_W-1:0]      rd_ptr;
    logic [UART_DATA_W-1:0] rd_data;
    logic                   push;
    logic                   pop;
    tx_state_t              state;
    tx_state_t              state_nxt;

    function automatic logic [ADDR_W:0] count_step(
        input logic [ADDR_W:0] cnt,
        input logic            do_push,
        input logic            do_pop
    );
        logic [ADDR_W:0] res;
        res = cnt;
        case ({do_push, do_pop})
            2'b10:   res = cnt + (ADDR_W + 1)'(1);
            2'b01:   res = cnt - (ADDR_W + 1)'(1);
            default: res = cnt;
        endcase
        return res;
    endfunction

    // full is taken from the registered count, so a pop on the same edge cannot admit a write.
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign push  = wrEn && !full;
    assign pop   = (state == S_IDLE) && !empty;

    sync_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (UART_DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wrData),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_step(count, push, pop);
        end
    end

    // Launch register: txByte holds the popped byte until the next launch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txByte <= '0;
        end else if (pop) begin
            txByte <= rd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!empty) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT:   if (txDone) state_nxt = S_GAP;
            S_GAP:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // S_GAP lets the transmitter settle back to idle before the next dataValid.
    always_comb begin
        txDataValid = 1'b0;
        busy        = 1'b0;
        case (state)
            S_LAUNCH: begin
                txDataValid = 1'b1;
                busy        = 1'b1;
            end
            S_WAIT:   busy = 1'b1;
            default: begin
                txDataValid = 1'b0;
                busy        = 1'b0;
            end
        endcase
    end

`ifdef UART_TX_FIFO_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (wrEn && full) begin
            ovf <= 1'b1;
        end
    end
`else
    // Without the flag, writes into a full FIFO are discarded silently.
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with a behavioural transmitter and launch scoreboard.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk;
    logic       rst;
    logic       wrEn;
    logic [7:0] wrData;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       txDataValid;
    logic [7:0] txByte;
    logic       txDone;
    logic       busy;
`ifdef UART_TX_FIFO_OVF_EN
    logic       ovf;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int launches = 0;
    int tx_lat = 4;
    int cd = 0;
    int done_edge = 0;
    bit tx_auto = 1'b0;
    bit pending = 1'b0;
    bit gap_arm = 1'b0;
    logic [7:0] q[$];
    logic [7:0] exp_b;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .wrEn        (wrEn),
        .wrData      (wrData),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .txDataValid (txDataValid),
        .txByte      (txByte),
        .txDone      (txDone),
        .busy        (busy)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .ovf         (ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Transmitter model and launch scoreboard, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (txDone) txDone = 1'b0;
        if (txDataValid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL launch_unexpected: txByte=%h launched, expected no launch", txByte);
            end else begin
                exp_b = q.pop_front();
                if (txByte !== exp_b) begin
                    errors++;
                    $display("FAIL launch_order: txByte=%h expected %h", txByte, exp_b);
                end
            end
            if (gap_arm) begin
                checks++;
                if (cyc - done_edge != 2) begin
                    errors++;
                    $display("FAIL launch_gap: %0d edges after txDone, expected 2", cyc - done_edge);
                end
                gap_arm = 1'b0;
            end
            launches++;
            pending = 1'b1;
            cd = tx_lat;
        end else if (pending && tx_auto) begin
            if (cd > 0) begin
                cd--;
            end else begin
                txDone = 1'b1;
                pending = 1'b0;
                done_edge = cyc + 1;
                gap_arm = (q.size() > 0);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input bit accept);
        wrEn = 1'b1;
        wrData = d;
        if (accept) q.push_back(d);
        tick();
        wrEn = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (q.size() == 0 && !pending && busy === 1'b0 && empty === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout: queue=%0d busy=%b empty=%b, expected drained within %0d cycles",
                     q.size(), busy, empty, budget);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        checks += 6;
        if (count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
        if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", empty); end
        if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", full); end
        if (txDataValid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", txDataValid); end
        if (txByte !== 8'h00) begin errors++; $display("FAIL rst_txbyte: got %h expected 00", txByte); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
`ifdef UART_TX_FIFO_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
`endif
    endtask

    task automatic test_single();
        tx_auto = 1'b1;
        tx_lat = 20;
        wr(8'hAB, 1'b1);
        checks += 2;
        if (count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
        if (txDataValid !== 1'b0) begin errors++; $display("FAIL single_early: valid=%b expected 0", txDataValid); end
        tick();
        checks += 4;
        if (txDataValid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", txDataValid); end
        if (txByte !== 8'hAB) begin errors++; $display("FAIL single_byte: got %h expected ab", txByte); end
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        if (count !== 5'd0) begin errors++; $display("FAIL single_popcount: got %0d expected 0", count); end
        tick();
        checks += 2;
        if (txDataValid !== 1'b0) begin errors++; $display("FAIL single_pulse: valid=%b expected 0", txDataValid); end
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_hold: got %b expected 1", busy); end
        wait_idle(100);
        checks++;
        if (txByte !== 8'hAB) begin errors++; $display("FAIL single_hold: txByte=%h expected ab", txByte); end
    endtask

    task automatic test_burst();
        logic [4:0] exp_cnt [5] = '{5'd1, 5'd1, 5'd2, 5'd3, 5'd4};
        int base = launches;
        tx_auto = 1'b1;
        tx_lat = 30;
        for (int i = 0; i < 5; i++) begin
            wr(8'(i + 1), 1'b1);
            checks++;
            if (count !== exp_cnt[i]) begin
                errors++;
                $display("FAIL burst_count%0d: got %0d expected %0d", i, count, exp_cnt[i]);
            end
        end
        wait_idle(400);
        checks += 2;
        if (launches - base != 5) begin errors++; $display("FAIL burst_launches: got %0d expected 5", launches - base); end
        if (empty !== 1'b1) begin errors++; $display("FAIL burst_empty: got %b expected 1", empty); end
    endtask

    task automatic test_full();
        int base = launches;
        tx_auto = 1'b0;
        tx_lat = 3;
        for (int i = 1; i <= 17; i++) begin
            wr(8'(i), 1'b1);
            if (i == 16) begin
                checks++;
                if (full !== 1'b0) begin errors++; $display("FAIL full_early: got %b expected 0", full); end
            end
        end
        checks += 3;
        if (count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d expected 16", count); end
        if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b expected 1", full); end
        if (empty !== 1'b0) begin errors++; $display("FAIL full_empty: got %b expected 0", empty); end
`ifdef UART_TX_FIFO_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", ovf); end
`endif
        wr(8'h12, 1'b0);
        checks += 2;
        if (count !== 5'd16) begin errors++; $display("FAIL drop_count: got %0d expected 16", count); end
        if (full !== 1'b1) begin errors++; $display("FAIL drop_full: got %b expected 1", full); end
`ifdef UART_TX_FIFO_OVF_EN
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ovf); end
`endif
        tx_auto = 1'b1;
        wait_idle(400);
        checks++;
        if (launches - base != 17) begin errors++; $display("FAIL full_drain: got %0d launches expected 17", launches - base); end
    endtask

    task automatic test_simul_push_pop();
        bit fell = 1'b0;
        tx_auto = 1'b0;
        tx_lat = 2;
        wr(8'hA1, 1'b1);
        wr(8'hA2, 1'b1);
        wr(8'hA3, 1'b1);
        wr(8'hA4, 1'b1);
        checks++;
        if (count !== 5'd3) begin errors++; $display("FAIL simul_setup: count=%0d expected 3", count); end
        tx_auto = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy === 1'b0) begin
                fell = 1'b1;
                break;
            end
        end
        checks++;
        if (!fell) begin errors++; $display("FAIL simul_busy_timeout: busy=%b expected 0 within 20 cycles", busy); end
        tick();
        wr(8'h5A, 1'b1);
        checks += 3;
        if (count !== 5'd3) begin errors++; $display("FAIL simul_count: got %0d expected 3", count); end
        if (txDataValid !== 1'b1) begin errors++; $display("FAIL simul_launch: valid=%b expected 1", txDataValid); end
        if (txByte !== 8'hA2) begin errors++; $display("FAIL simul_byte: got %h expected a2", txByte); end
        wait_idle(200);
    endtask

    task automatic test_wrap();
        int base = launches;
        tx_auto = 1'b1;
        tx_lat = 1;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 10; k++) begin
                wr(8'(b * 10 + k) ^ 8'h3F, 1'b1);
            end
            wait_idle(200);
        end
        checks++;
        if (launches - base != 40) begin errors++; $display("FAIL wrap_launches: got %0d expected 40", launches - base); end
    endtask

    task automatic test_reset_mid();
        int base;
        tx_auto = 1'b0;
        tx_lat = 5;
        for (int i = 0; i < 6; i++) wr(8'hC0 + 8'(i), 1'b1);
        tick();
        tick();
        checks += 2;
        if (count !== 5'd5) begin errors++; $display("FAIL mid_setup: count=%0d expected 5", count); end
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        checks += 5;
        if (count !== 5'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", count); end
        if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b expected 1", empty); end
        if (full !== 1'b0) begin errors++; $display("FAIL mid_full: got %b expected 0", full); end
        if (txDataValid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", txDataValid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_clr: got %b expected 0", busy); end
`ifdef UART_TX_FIFO_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b expected 0", ovf); end
`endif
        q.delete();
        tick();
        rst = 1'b0;
        tx_auto = 1'b1;
        base = launches;
        repeat (15) tick();
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL stale_busy: got %b expected 0", busy); end
        if (empty !== 1'b1) begin errors++; $display("FAIL stale_empty: got %b expected 1", empty); end
        if (launches != base) begin errors++; $display("FAIL stale_launch: got %0d launches expected 0", launches - base); end
        repeat (20) tick();
        wr(8'h3F, 1'b1);
        wait_idle(100);
        checks++;
        if (launches - base != 1) begin errors++; $display("FAIL post_rst_tx: got %0d launches expected 1", launches - base); end
    endtask

    initial begin
        rst = 1'b1;
        wrEn = 1'b0;
        wrData = 8'h00;
        txDone = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        tick();
        test_single();
        test_burst();
        test_full();
        test_simul_push_pop();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer and launch controller directly upstream of uartTransmiter.
- Accepts bytes from a producer (command/response logic) on a one-cycle write strobe and stores them in a circular FIFO.
- Drives the transmitter's dataValid/P_BYTE with one byte at a time, then waits for the transmitter's done pulse before launching the next.
- Lets producers burst bytes without tracking the 1042-clocks-per-bit serial timing.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- wrEn  input  1  write strobe; byte accepted on the clock edge when wrEn=1 and full=0
- wrData  input  8  byte to enqueue
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  ADDR_W+1  bytes currently stored (excludes the byte in flight)
- txDataValid  output  1  one-cycle launch pulse; connects to transmitter dataValid
- txByte  output  8  byte being launched; connects to transmitter P_BYTE; held stable until the next launch
- txDone  input  1  transmitter done pulse (one cycle, end of stop bit)
- busy  output  1  high from launch until txDone is consumed

Behaviour:
- Reset (async, while rst=1): pointers=0, count=0, empty=1, full=0, txDataValid=0, txByte=8'h00, busy=0, FSM=S_IDLE; memory contents are don't-care.
- Write: on an edge with wrEn=1 and full=0, mem[wrPtr]<=wrData, wrPtr+=1 (wraps modulo DEPTH).
- Write while full=1 is dropped; FIFO contents are unchanged.
- FSM states:
  - S_IDLE: if count>0, pop mem[rdPtr] into txByte, rdPtr+=1, txDataValid<=1, busy<=1, go to S_LAUNCH.
  - S_LAUNCH: txDataValid<=0, go to S_WAIT.
  - S_WAIT: stay until txDone=1, then busy<=0 and go to S_GAP.
  - S_GAP: one-cycle turnaround, go to S_IDLE. This guarantees the transmitter has returned to idle before the next dataValid.
- Latency: a byte written into an empty, idle FIFO at edge N produces txDataValid=1 after edge N+1 (visible for cycle N+1..N+2).
- Back-to-back: next launch occurs 2 edges after the edge that samples txDone.
- count update:
  - push only: +1
  - pop only: -1
  - push and pop on the same edge: unchanged
- Full-boundary precedence: full is evaluated before the pop, so a write when count==DEPTH is dropped even if a pop occurs on the same edge.
- Empty boundary: pop occurs only when count>0; a write on the same edge as count==0 is not popped until the next edge.
- Spurious txDone is ignored in every state except S_WAIT.
- Reset mid-transmission: the FIFO empties and the FSM returns to S_IDLE.
  - The transmitter has no reset, so the in-flight serial byte completes.
  - Its trailing txDone arrives in S_IDLE and is ignored.
  - The producer must not write within one character time (10×CLKS_PER_BIT clocks) after reset release.
- Pointer wrap: rdPtr and wrPtr are ADDR_W bits and wrap naturally; full/empty come from count, never from pointer comparison.

Optional Feature:
- Macro: UART_TX_FIFO_OVF_EN.
- Defined: adds output port ovf (1 bit), a sticky flag set on any dropped write (wrEn=1 while full=1), cleared only by rst; reset value 0.
- Not defined: port ovf is absent and dropped writes are silent. All other behaviour is identical.

Decomposition:
- Shared package uart_pkg:
  - localparam UART_DATA_W=8.
  - FSM state enum typedef (S_IDLE, S_LAUNCH, S_WAIT, S_GAP), 2 bits.
  - Default DEPTH constant.
- One natural sub-module: sync_fifo_mem, a DEPTH×8 register array with write port and combinational read at rdPtr; pointers, count and FSM stay in uart_tx_fifo.

Test Plan:
- Single byte: reset, write 8'hAB at cycle 3 → txDataValid=1 for exactly one cycle at cycle 4 with txByte=8'hAB; busy=1 until txDone; with uartTransmiter attached, the serial line shows 0xAB LSB-first.
- Burst ordering: write 8'h01..8'h05 on consecutive cycles → launches in order 01,02,03,04,05; each launch exactly 2 edges after the preceding txDone; count goes 1→…→4 then decrements; empty=1 after the last pop.
- Full/overflow: hold txDone=0, write DEPTH+1 bytes (01..11h) → full=1 after the 16th stored byte (1 popped into flight, so 17 accepted); the 18th write is dropped; ovf=1 when UART_TX_FIFO_OVF_EN is defined; drain yields 01..11h with no loss or duplication.
- Simultaneous push/pop: with count=3 in S_IDLE, write 8'h5A on the pop edge → count stays 3; 8'h5A emerges in order after the existing bytes.
- Wrap-around: 40 bytes (pattern i^8'h3F) through DEPTH=16 → all 40 are received by a UART_RX loopback in order, matching the pattern.
- Reset mid-operation: assert rst for 1 cycle during S_WAIT with count=5 → count=0, empty=1, txDataValid=0, busy=0 immediately; stale txDone is ignored; after a 10-bit-time wait, writing 8'h3F transmits correctly.
